// File: rtl/rate_enable_pkg.sv
// Shared types and default widths for the rate enable generator.
//   mode_e      : pulse placement within a period (SPREAD / BURST)
//   ch_state_e  : per-channel run state
//   ch_cfg_t    : channel configuration payload {num, den, mode, en}
package rate_enable_pkg;

  localparam int unsigned DEF_NUM_CH  = 2;
  localparam int unsigned DEF_RATIO_W = 8;
  // Storage width of the config payload; RATIO_W must not exceed it.
  localparam int unsigned RATIO_MAX_W = 16;

  typedef enum logic {
    MODE_SPREAD = 1'b0,
    MODE_BURST  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [RATIO_MAX_W-1:0] num;
    logic [RATIO_MAX_W-1:0] den;
    mode_e                  mode;
    logic                   en;
  } ch_cfg_t;

  // Channel index width, never below one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rate_enable_gen_if.sv
// Configuration bus of the rate enable generator.
//   master : drives cfg_valid/cfg_ch/cfg_num/cfg_den/cfg_mode/cfg_en, sees cfg_ready/cfg_err
//   slave  : the generator; cfg_ready is combinational, cfg_err a one-cycle pulse
interface rate_enable_gen_if
  import rate_enable_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned RATIO_W = DEF_RATIO_W
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [RATIO_W-1:0] cfg_num;
  logic [RATIO_W-1:0] cfg_den;
  mode_e              cfg_mode;
  logic               cfg_en;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_num, cfg_den, cfg_mode, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_num, cfg_den, cfg_mode, cfg_en,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/rate_enable_ch.sv
// One enable channel: shadow/pending config, IDLE/RUN state, period phase
// and SPREAD accumulator; emits registered clk_enable and period_start.
//   clk, rst      : clock, synchronous active-high reset
//   trigger       : global advance
//   load/load_cfg : accepted valid request for this channel
//   pending       : shadow holds a config not yet applied
//   clk_enable    : pulse decision of the previous active cycle
//   period_start  : previous active cycle was phase 0
module rate_enable_ch
  import rate_enable_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    trigger,
  input  logic    load,
  input  ch_cfg_t load_cfg,
  output logic    pending,
  output logic    clk_enable,
  output logic    period_start
);

  ch_state_e              state;
  ch_cfg_t                cur;
  ch_cfg_t                shadow;
  logic [RATIO_MAX_W-1:0] phase;
  logic [RATIO_MAX_W-1:0] acc;

  logic                   active;
  logic                   boundary;
  logic                   pulse;
  logic [RATIO_MAX_W:0]   sum;

  // Pulse decision for the current cycle; sum carries one extra bit so acc+num never wraps.
  always_comb begin
    active   = trigger && (state == ST_RUN);
    boundary = active && (phase == (cur.den - RATIO_MAX_W'(1)));
    sum      = {1'b0, acc} + {1'b0, cur.num};
    if (cur.mode == MODE_BURST) pulse = (phase < cur.num);
    else                        pulse = (sum >= {1'b0, cur.den});
  end

  // Channel state, config handover and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cur          <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      phase        <= '0;
      acc          <= '0;
      clk_enable   <= 1'b0;
      period_start <= 1'b0;
    end else begin
      clk_enable   <= active && pulse;
      period_start <= active && (phase == '0);

      if (load) begin
        shadow  <= load_cfg;
        pending <= 1'b1;
      end

      if (active) begin
        phase <= boundary ? '0 : phase + RATIO_MAX_W'(1);
        if (cur.mode == MODE_SPREAD)
          acc <= pulse ? RATIO_MAX_W'(sum - {1'b0, cur.den}) : RATIO_MAX_W'(sum);
      end

      // Load only happens while pending is clear, so it never races the handover.
      if (pending && ((state == ST_IDLE) || boundary)) begin
        cur     <= shadow;
        pending <= 1'b0;
        phase   <= '0;
        acc     <= '0;
        state   <= shadow.en ? ST_RUN : ST_IDLE;
      end else if (boundary && !cur.en) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: rtl/rate_enable_gen.sv
// Multi-channel fractional clock-enable generator (num pulses per den triggers).
//   clk, rst     : clock, synchronous active-high reset
//   trigger      : global advance
//   cfg          : configuration bus (slave side)
//   clk_enable   : per-channel enable pulses
//   period_start : per-channel first-active-cycle-of-period pulses
module rate_enable_gen
  import rate_enable_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned RATIO_W = DEF_RATIO_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  rate_enable_gen_if.slave    cfg,
  output logic [NUM_CH-1:0]   clk_enable,
  output logic [NUM_CH-1:0]   period_start
);

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;
  logic              ready_c;
  logic              hs;
  logic              bad;
  ch_cfg_t           req_cfg;

  // An out-of-range channel selects nothing, so it is always ready and flagged bad.
  always_comb begin
    ready_c = ~|(sel & pending);
    hs      = cfg.cfg_valid && ready_c;
    bad     = (cfg.cfg_den == '0) || (cfg.cfg_num > cfg.cfg_den) || !(|sel);
    req_cfg = '{num:  RATIO_MAX_W'(cfg.cfg_num),
                den:  RATIO_MAX_W'(cfg.cfg_den),
                mode: cfg.cfg_mode,
                en:   cfg.cfg_en};
  end

  assign cfg.cfg_ready = ready_c;

  // Invalid requests are consumed and reported one cycle later.
  always_ff @(posedge clk) begin
    if (rst) cfg.cfg_err <= 1'b0;
    else     cfg.cfg_err <= hs && bad;
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    assign sel[g]  = (32'(cfg.cfg_ch) == 32'(g));
    assign load[g] = hs && !bad && sel[g];

    rate_enable_ch u_ch (
      .clk          (clk),
      .rst          (rst),
      .trigger      (trigger),
      .load         (load[g]),
      .load_cfg     (req_cfg),
      .pending      (pending[g]),
      .clk_enable   (clk_enable[g]),
      .period_start (period_start[g])
    );
  end

endmodule

// File: tb/tb_rate_enable_gen.sv
// Scoreboard bench for rate_enable_gen: a reference model predicts each
// cycle's outputs as stimulus is driven, the DUT result is popped and compared.
module tb_rate_enable_gen;
  import rate_enable_pkg::*;

  localparam int unsigned NCH = 3;
  localparam int unsigned RW  = 8;

  logic clk = 1'b0;
  logic rst;
  logic trigger;
  logic [NCH-1:0] clk_enable;
  logic [NCH-1:0] period_start;

  rate_enable_gen_if #(.NUM_CH(NCH), .RATIO_W(RW)) cfg_if ();

  rate_enable_gen #(.NUM_CH(NCH), .RATIO_W(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .cfg          (cfg_if),
    .clk_enable   (clk_enable),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           err;
    logic [NCH-1:0] ps;
    logic [NCH-1:0] ce;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  bit m_run[NCH];
  bit m_burst[NCH];
  bit m_pend[NCH];
  int m_num[NCH];
  int m_den[NCH];
  int m_phase[NCH];
  int s_num[NCH];
  int s_den[NCH];
  bit s_burst[NCH];
  bit s_en[NCH];

  logic [NCH-1:0] obs_ce;
  logic [NCH-1:0] obs_ps;
  logic           obs_err;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SPREAD places pulse k at the first phase where floor(p*num/den) steps up.
  function automatic bit spread_hit(input int p, input int n, input int d);
    return ((p + 1) * n) / d > (p * n) / d;
  endfunction

  task automatic tick(input logic trig);
    exp_t e;
    int   ch, num, den;
    bit   rdy, hs, bad, act, pulse, bnd;
    trigger = trig;
    #1;
    ch  = int'(cfg_if.cfg_ch);
    num = int'(cfg_if.cfg_num);
    den = int'(cfg_if.cfg_den);
    rdy = (ch < int'(NCH)) ? !m_pend[ch] : 1'b1;
    check("cfg_ready", int'(cfg_if.cfg_ready), int'(rdy));
    e = '0;
    if (rst) begin
      for (int c = 0; c < int'(NCH); c++) begin
        m_run[c] = 0; m_burst[c] = 0; m_pend[c] = 0;
        m_num[c] = 0; m_den[c] = 0; m_phase[c] = 0;
        s_num[c] = 0; s_den[c] = 0; s_burst[c] = 0; s_en[c] = 0;
      end
    end else begin
      hs    = cfg_if.cfg_valid && rdy;
      bad   = (den == 0) || (num > den) || (ch >= int'(NCH));
      e.err = hs && bad;
      for (int c = 0; c < int'(NCH); c++) begin
        act   = trig && m_run[c];
        pulse = 0;
        if (act) pulse = m_burst[c] ? (m_phase[c] < m_num[c])
                                    : spread_hit(m_phase[c], m_num[c], m_den[c]);
        e.ce[c] = act && pulse;
        e.ps[c] = act && (m_phase[c] == 0);
        bnd     = act && (m_phase[c] == m_den[c] - 1);
        if (act) m_phase[c] = bnd ? 0 : m_phase[c] + 1;
        if (m_pend[c] && (!m_run[c] || bnd)) begin
          m_num[c] = s_num[c]; m_den[c] = s_den[c]; m_burst[c] = s_burst[c];
          m_run[c] = s_en[c]; m_phase[c] = 0; m_pend[c] = 0;
        end
        if (hs && !bad && ch == c) begin
          s_num[c] = num; s_den[c] = den;
          s_burst[c] = (cfg_if.cfg_mode == MODE_BURST); s_en[c] = cfg_if.cfg_en;
          m_pend[c] = 1;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_ce  = clk_enable;
    obs_ps  = period_start;
    obs_err = cfg_if.cfg_err;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("clk_enable", int'(obs_ce), int'(e.ce));
      check("period_start", int'(obs_ps), int'(e.ps));
      check("cfg_err", int'(obs_err), int'(e.err));
    end
  endtask

  task automatic send(input int ch, input int num, input int den,
                      input mode_e mode, input logic en, input logic trig);
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_num   = 8'(num);
    cfg_if.cfg_den   = 8'(den);
    cfg_if.cfg_mode  = mode;
    cfg_if.cfg_en    = en;
    cfg_if.cfg_valid = 1'b1;
    tick(trig);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_if.cfg_ready && n < 20) begin
      tick(1'b1);
      n++;
    end
    check("ready_timeout", int'(cfg_if.cfg_ready), 1);
  endtask

  initial begin : main
    logic [7:0] pat_ce, pat_ps;
    int         cnt;
    logic [NCH-1:0] any_ce;

    rst = 1'b1; trigger = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_num = '0;
    cfg_if.cfg_den = '0; cfg_if.cfg_mode = MODE_SPREAD; cfg_if.cfg_en = 1'b0;

    // request presented during reset must be dropped
    cfg_if.cfg_ch = 2'd0; cfg_if.cfg_num = 8'd2; cfg_if.cfg_den = 8'd3;
    cfg_if.cfg_mode = MODE_BURST; cfg_if.cfg_en = 1'b1; cfg_if.cfg_valid = 1'b1;
    tick(1'b1); tick(1'b1);
    cfg_if.cfg_valid = 1'b0; rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin tick(1'b1); cnt += int'(obs_ce != '0); end
    check("rst_no_pulse", cnt, 0);
    check("rst_ready", int'(cfg_if.cfg_ready), 1);

    // ch0 2/3 BURST from IDLE
    send(0, 2, 3, MODE_BURST, 1'b1, 1'b1);
    tick(1'b1);
    pat_ce = '0; pat_ps = '0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1);
      pat_ce = {pat_ce[6:0], obs_ce[0]}; pat_ps = {pat_ps[6:0], obs_ps[0]};
    end
    check("burst_pattern", int'(pat_ce), 8'b0011_0110);
    check("burst_pstart", int'(pat_ps), 8'b0010_0100);

    // ch0 to 2/3 SPREAD, applied at the period boundary
    send(0, 2, 3, MODE_SPREAD, 1'b1, 1'b1);
    check("ready_drop", int'(cfg_if.cfg_ready), 0);
    wait_ready();
    pat_ce = '0; pat_ps = '0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1);
      pat_ce = {pat_ce[6:0], obs_ce[0]}; pat_ps = {pat_ps[6:0], obs_ps[0]};
    end
    check("spread_pattern", int'(pat_ce), 8'b0001_1011);
    check("spread_pstart", int'(pat_ps), 8'b0010_0100);

    // mid-period reconfiguration to 1/4
    for (int k = 0; k < 5 && m_phase[0] != 1; k++) tick(1'b1);
    send(0, 1, 4, MODE_SPREAD, 1'b1, 1'b1);
    check("mid_ready_low", int'(cfg_if.cfg_ready), 0);
    wait_ready();
    pat_ce = '0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1);
      pat_ce = {pat_ce[6:0], obs_ce[0]};
    end
    check("quarter_pattern", int'(pat_ce), 8'b0001_0001);

    // invalid requests
    send(0, 5, 4, MODE_SPREAD, 1'b1, 1'b1);
    check("err_num_gt_den", int'(obs_err), 1);
    check("err_keeps_ready", int'(cfg_if.cfg_ready), 1);
    send(0, 1, 0, MODE_BURST, 1'b1, 1'b1);
    check("err_den_zero", int'(obs_err), 1);
    send(int'(NCH), 1, 2, MODE_SPREAD, 1'b1, 1'b1);
    check("err_bad_ch", int'(obs_err), 1);
    tick(1'b1);
    check("err_one_cycle", int'(obs_err), 0);

    // ch1 3/8 SPREAD with trigger on alternate cycles
    send(1, 3, 8, MODE_SPREAD, 1'b1, 1'b0);
    tick(1'b0);
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      tick(k % 2 == 0);
      cnt += int'(obs_ce[1]);
      if (k % 2 == 1) check("ch1_low_trig", int'(obs_ce[1]), 0);
    end
    check("ch1_pulses_16act", cnt, 6);

    // ch2 num=0 never pulses, then num=den pulses every active cycle
    send(2, 0, 3, MODE_SPREAD, 1'b1, 1'b1);
    cnt = 0;
    for (int k = 0; k < 7; k++) begin tick(1'b1); cnt += int'(obs_ce[2]); end
    check("num0_cnt", cnt, 0);
    send(2, 5, 5, MODE_SPREAD, 1'b1, 1'b1);
    wait_ready();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin tick(1'b1); cnt += int'(obs_ce[2]); end
    check("numden_cnt", cnt, 5);
    send(2, 1, 2, MODE_BURST, 1'b0, 1'b1);
    wait_ready();
    cnt = 0;
    for (int k = 0; k < 4; k++) begin tick(1'b1); cnt += int'(obs_ce[2]); end
    check("disabled_cnt", cnt, 0);

    // reset mid-period with ch0 and ch1 running
    tick(1'b1);
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    check("rst_ce", int'(obs_ce), 0);
    check("rst_ps", int'(obs_ps), 0);
    check("rst_err", int'(obs_err), 0);
    any_ce = '0;
    for (int k = 0; k < 8; k++) begin tick(1'b1); any_ce |= obs_ce; end
    check("post_rst_quiet", int'(any_ce), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rate_enable_gen.md
RATE_ENABLE_GEN -- requirements
Module: rate_enable_gen

Interface
REQ-001 SHALL expose parameter NUM_CH, default 2, number of independent enable channels (1..8).
REQ-002 SHALL expose parameter RATIO_W, default 8, width of the ratio numerator and denominator.
REQ-003 SHALL have one clock, clk; reset rst is synchronous, active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 trigger  input  1  global advance; a channel counts only in cycles with trigger=1.
REQ-007 cfg_valid  input  1  configuration request.
REQ-008 cfg_ready  output  1  combinational; =1 when channel cfg_ch has no pending configuration.
REQ-009 cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel.
REQ-010 cfg_num  input  RATIO_W  output pulses per period.
REQ-011 cfg_den  input  RATIO_W  trigger cycles per period.
REQ-012 cfg_mode  input  1  0=SPREAD (evenly distributed), 1=BURST (pulses at start of period).
REQ-013 cfg_en  input  1  channel run enable.
REQ-014 cfg_err  output  1  one-cycle pulse on an accepted but invalid request.
REQ-015 clk_enable  output  NUM_CH  registered per-channel enable pulses.
REQ-016 period_start  output  NUM_CH  registered pulse, coincident with the first active cycle of each period.

Function
REQ-017 A handshake SHALL occur when cfg_valid and cfg_ready are both 1; the request SHALL be captured into that channel's shadow register and the pending flag SHALL be set.
REQ-018 A request with den=0, num>den, or cfg_ch>=NUM_CH SHALL be accepted, discarded, and SHALL pulse cfg_err in the next cycle; pending SHALL be unchanged.
REQ-019 Per-channel states: IDLE (disabled) and RUN.
REQ-020 In IDLE, a pending config SHALL apply in the next cycle; phase and acc SHALL clear; the state SHALL become RUN if en=1.
REQ-021 In RUN, a pending config SHALL apply only at the period boundary (an active cycle with phase==den-1); phase and acc SHALL clear; the state SHALL go to IDLE if en=0.
REQ-022 Active cycle: trigger=1 and state RUN; phase SHALL advance 0..den-1 and wrap to 0.
REQ-023 SPREAD: sum=acc+num, computed at RATIO_W+1 bits; if sum>=den then pulse and acc<=sum-den, else acc<=sum.
REQ-024 BURST: pulse iff phase<num.
REQ-025 The pulse decision for active cycle t SHALL appear on clk_enable in cycle t+1 (one-cycle latency); otherwise clk_enable=0.
REQ-026 trigger=0 SHALL freeze phase and acc and drive clk_enable=0 and period_start=0 in the next cycle.
REQ-027 num=0 SHALL never pulse; num=den SHALL pulse every active cycle.
REQ-028 Every period SHALL contain exactly num pulses in both modes.
REQ-029 Channels SHALL be fully independent; a handshake on one channel SHALL not perturb another.
REQ-030 A handshake coinciding with a boundary SHALL set pending; that config SHALL apply at the following boundary.

Reset
REQ-031 rst SHALL clear all channels to IDLE, num=den=0, phase=acc=0, pending=0.
REQ-032 rst SHALL drive clk_enable=0, period_start=0 and cfg_err=0 in the next cycle.
REQ-033 rst SHALL take priority over trigger and the handshake; a request presented during reset SHALL be dropped.

Structure
REQ-034 A shared package rate_enable_pkg SHALL hold the mode enum (MODE_SPREAD, MODE_BURST), the channel config struct {num, den, mode, en}, and the default widths.
REQ-035 The per-channel datapath (state, phase, acc, shadow, pending) SHALL be a sub-module rate_enable_ch, instantiated NUM_CH times by a generate loop.
REQ-036 The top level SHALL contain only cfg decode and validation, cfg_ready mux and output concatenation.

Verification
REQ-037 ch0 is configured num=2, den=3, BURST, en=1, with trigger held high; clk_enable[0] SHALL repeat 1,1,0 and period_start[0] SHALL pulse every 3 cycles.
REQ-038 ch0 is configured num=2, den=3, SPREAD; clk_enable[0] SHALL repeat 0,1,1.
REQ-039 ch1 is configured num=3, den=8, SPREAD, trigger 1 on alternate cycles; the bench SHALL count exactly 3 pulses per 8 active cycles, with none in trigger-low cycles.
REQ-040 ch0 runs 2/3 and is reconfigured to 1/4 mid-period; cfg_ready SHALL go 0, the old pattern SHALL finish the period, 1/4 SHALL start at the boundary, and cfg_ready SHALL return to 1.
REQ-041 Requests num=5/den=4 and den=0 SHALL each produce one cfg_err pulse with no output change; cfg_ch=NUM_CH SHALL also produce cfg_err.
REQ-042 rst asserted mid-period with both channels running SHALL give all outputs 0 next cycle and no pulses until reconfigured.
